// File: rtl/neur_pkg.sv
// Shared types for the neural decoder sequencer: precision modes, FSM states,
// the decoder beat payload and the weight-words-per-activation helper.
package neur_pkg;

  typedef enum logic [1:0] {
    NEUR_MODE_W8_BCAST = 2'b00,
    NEUR_MODE_W8_LANE  = 2'b01,
    NEUR_MODE_W4       = 2'b10,
    NEUR_MODE_W2       = 2'b11
  } neur_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } neur_state_e;

  typedef struct packed {
    logic [31:0] weights;
    logic [31:0] inputs;
    logic [1:0]  iteration;
    logic [2:0]  mode;
    logic        first;
    logic        last;
  } beat_t;

  // Weight words consumed per activation word for a precision mode.
  function automatic logic [2:0] words_per_act(input logic [1:0] mode);
    logic [2:0] n;
    case (neur_mode_e'(mode))
      NEUR_MODE_W8_BCAST: n = 3'd4;
      NEUR_MODE_W4:       n = 3'd2;
      default:            n = 3'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/neur_beat_reg.sv
// Valid/ready output register for decoder beats. A beat, once presented,
// holds with stable payload until ready; load may replace it on the accept cycle.
module neur_beat_reg
  import neur_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clear,
  input  logic  load,
  input  logic  ready,
  input  beat_t payload,
  output logic  valid,
  output beat_t beat
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      beat  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      beat  <= payload;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/neur_seq_ctrl.sv
// Job sequencer feeding the mixed-precision decoder/MAC datapath.
// Optional performance counters are built when NEUR_SEQ_PERF_EN is defined.
module neur_seq_ctrl
  import neur_pkg::*;
#(
  parameter int unsigned LEN_W        = 16,
  parameter int unsigned ACT_HOLD_MAX = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       mode_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  input  logic             act_valid_i,
  output logic             act_ready_o,
  input  logic [31:0]      act_data_i,
  input  logic             wgt_valid_i,
  output logic             wgt_ready_o,
  input  logic [31:0]      wgt_data_i,
  output logic             dec_valid_o,
  input  logic             dec_ready_i,
  output logic [2:0]       dec_mode_o,
  output logic [1:0]       dec_iteration_o,
  output logic [31:0]      dec_weights_o,
  output logic [31:0]      dec_inputs_o,
  output logic             dec_first_o,
`ifdef NEUR_SEQ_PERF_EN
  output logic             dec_last_o,
  output logic [31:0]      perf_stall_cnt_o,
  output logic [31:0]      perf_starve_cnt_o
`else
  output logic             dec_last_o
`endif
);

  localparam int unsigned SUB_W = (ACT_HOLD_MAX > 4) ? $clog2(ACT_HOLD_MAX) : 2;

  // All streams: a word transfers on a cycle where valid and ready are both
  // high at the clock edge; a producer holds valid and data until that cycle.

  neur_state_e      state_q, state_d;
  logic [2:0]       mode_q;
  logic [LEN_W-1:0] remaining;
  logic [SUB_W-1:0] sub;
  logic             act_held;
  logic [31:0]      act_q;
  logic             first_pend;

  logic             in_run, act_hs, step, release_act, last_accept, start_acc;
  logic [2:0]       n_words;
  logic [1:0]       iteration;
  beat_t            payload, beat;

  assign in_run      = (state_q == RUN);
  assign start_acc   = (state_q == IDLE) && start_i;
  assign act_ready_o = in_run && !abort_i && !act_held;
  assign act_hs      = act_ready_o && act_valid_i;
  assign step        = in_run && !abort_i && act_held && wgt_valid_i &&
                       (!dec_valid_o || dec_ready_i) && (remaining != '0);
  assign wgt_ready_o = step;
  assign n_words     = words_per_act(mode_q[1:0]);
  assign release_act = (sub == SUB_W'(n_words - 3'd1)) || (remaining == LEN_W'(1));
  assign last_accept = dec_valid_o && dec_ready_i && dec_last_o;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);

  always_comb begin
    iteration = 2'd0;
    case (neur_mode_e'(mode_q[1:0]))
      NEUR_MODE_W8_BCAST: iteration = sub[1:0];
      NEUR_MODE_W4:       iteration = {1'b0, sub[0]};
      default:            iteration = 2'd0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_i) state_d = (len_i == '0) ? DONE : RUN;
      RUN: begin
        if (abort_i)          state_d = IDLE;
        else if (last_accept) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q     <= '0;
      remaining  <= '0;
      sub        <= '0;
      act_held   <= 1'b0;
      act_q      <= '0;
      first_pend <= 1'b0;
    end else if (start_acc) begin
      mode_q     <= mode_i;
      remaining  <= len_i;
      sub        <= '0;
      act_held   <= 1'b0;
      first_pend <= 1'b1;
    end else if (in_run && abort_i) begin
      act_held <= 1'b0;
      sub      <= '0;
    end else begin
      // act_hs needs !act_held and step needs act_held, so they never collide.
      if (act_hs) begin
        act_q    <= act_data_i;
        act_held <= 1'b1;
      end
      if (step) begin
        remaining  <= remaining - LEN_W'(1);
        first_pend <= 1'b0;
        if (release_act) begin
          sub      <= '0;
          act_held <= 1'b0;
        end else begin
          sub <= sub + SUB_W'(1);
        end
      end
    end
  end

  always_comb begin
    payload           = '0;
    payload.weights   = wgt_data_i;
    payload.inputs    = act_q;
    payload.iteration = iteration;
    payload.mode      = mode_q;
    payload.first     = first_pend;
    payload.last      = (remaining == LEN_W'(1));
  end

  neur_beat_reg u_beat_reg (
    .clk     (clk_i),
    .rst     (rst_i),
    .clear   (in_run && abort_i),
    .load    (step),
    .ready   (dec_ready_i),
    .payload (payload),
    .valid   (dec_valid_o),
    .beat    (beat)
  );

  assign dec_weights_o   = beat.weights;
  assign dec_inputs_o    = beat.inputs;
  assign dec_iteration_o = beat.iteration;
  assign dec_mode_o      = beat.mode;
  assign dec_first_o     = beat.first;
  assign dec_last_o      = beat.last;

`ifdef NEUR_SEQ_PERF_EN
  logic stall_cond, starve_cond;
  assign stall_cond  = in_run && act_held && wgt_valid_i && dec_valid_o && !dec_ready_i;
  assign starve_cond = in_run && !step && !dec_valid_o;

  always_ff @(posedge clk_i) begin
    if (rst_i || start_acc) begin
      perf_stall_cnt_o  <= '0;
      perf_starve_cnt_o <= '0;
    end else begin
      if (stall_cond && (perf_stall_cnt_o != '1))
        perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
      if (starve_cond && (perf_starve_cnt_o != '1))
        perf_starve_cnt_o <= perf_starve_cnt_o + 32'd1;
    end
  end
`endif

endmodule
